// File: rtl/yuv_ctrl_pkg.sv
// Shared constants for the YUV422 frame controller: FSM encoding, marker tag layout
// and default frame geometry.
package yuv_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

    // Bit positions inside one marker-delay-line entry
    localparam int unsigned TAG_VALID = 0;
    localparam int unsigned TAG_SOF   = 1;
    localparam int unsigned TAG_EOL   = 2;
    localparam int unsigned TAG_EOF   = 3;
    localparam int unsigned TAG_ABORT = 4;
    localparam int unsigned TAG_W     = 5;

    localparam int unsigned DEF_WORDS_PER_LINE  = 480;
    localparam int unsigned DEF_LINES_PER_FRAME = 1080;
    localparam int unsigned DEF_CONV_LATENCY    = 5;
    localparam int unsigned DEF_CNT_W           = 12;

endpackage

// File: rtl/marker_delay_line.sv
// Fixed-depth shift register carrying beat tags alongside the converter pipeline;
// synchronous active-low clear empties every stage.
module marker_delay_line
    import yuv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = TAG_W,
    parameter int unsigned DEPTH = DEF_CONV_LATENCY
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/yuv_frame_ctrl.sv
// Frame sequencer around the RGB-to-YUV422 converter: arms capture per frame, gates
// beats, tracks geometry, aligns SOF/EOL/EOF with converter output and drops frames.
module yuv_frame_ctrl
    import yuv_ctrl_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int unsigned CONV_LATENCY    = DEF_CONV_LATENCY,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        frame_start_i,
    input  logic        rgb_valid_i,
    input  logic        fifo_afull_i,
    output logic        conv_valid_o,
    input  logic        yuv_valid_i,
    output logic        out_valid_o,
    output logic        sof_o,
    output logic        eol_o,
    output logic        eof_o,
    output logic        abort_o,
    input  logic        err_clr_i,
    output logic        err_o,
    output logic [15:0] drop_cnt_o,
    output logic        busy_o
);

    localparam int unsigned SUP_W = $clog2(CONV_LATENCY + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_base;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_word;
    logic [CNT_W-1:0] r_line;
    logic [CNT_W-1:0] w_word_cur;
    logic [CNT_W-1:0] w_line_cur;
    logic             r_first;
    logic             r_err;
    logic [15:0]      r_drop_cnt;
    logic [SUP_W-1:0] r_sup;

    logic             w_capture;
    logic             w_restart;
    logic             w_drop_inc;
    logic             w_abort;
    logic             w_short;
    logic             w_beat;
    logic             w_sof;
    logic             w_eol;
    logic             w_eof;
    logic             w_chk_en;
    logic             w_align_err;
    logic             w_out_valid;
    logic [TAG_W-1:0] w_tag_in;
    logic [TAG_W-1:0] w_tag_dly;

    // The frame_start beat is forwarded in the same cycle the FSM enters ACTIVE
    always_comb begin
        w_next_base = r_state;
        w_capture   = 1'b0;
        w_restart   = 1'b0;
        w_drop_inc  = 1'b0;
        w_abort     = 1'b0;
        w_short     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_next_base = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF, ST_DROP: begin
                if (frame_start_i) begin
                    if (!enable_i) begin
                        w_next_base = ST_IDLE;
                    end else if (fifo_afull_i) begin
                        w_next_base = ST_DROP;
                        w_drop_inc  = 1'b1;
                    end else begin
                        w_next_base = ST_ACTIVE;
                        w_capture   = 1'b1;
                        w_restart   = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (fifo_afull_i) begin
                    w_next_base = ST_DROP;
                    w_drop_inc  = 1'b1;
                    w_abort     = 1'b1;
                end else if (frame_start_i) begin
                    w_short = 1'b1;
                    if (!enable_i) begin
                        w_next_base = ST_IDLE;
                    end else begin
                        w_capture = 1'b1;
                        w_restart = 1'b1;
                    end
                end else begin
                    w_capture = 1'b1;
                end
            end
            default: w_next_base = ST_IDLE;
        endcase
    end

    assign w_beat     = reset_i & w_capture & rgb_valid_i;
    assign w_word_cur = w_restart ? '0 : r_word;
    assign w_line_cur = w_restart ? '0 : r_line;
    assign w_sof      = w_restart | r_first;
    assign w_eol      = (w_word_cur == CNT_W'(WORDS_PER_LINE - 1));
    assign w_eof      = w_eol && (w_line_cur == CNT_W'(LINES_PER_FRAME - 1));

    assign w_next_state = (w_beat && w_eof) ? (enable_i ? ST_WAIT_SOF : ST_IDLE)
                                            : w_next_base;

    always_comb begin
        w_tag_in            = '0;
        w_tag_in[TAG_VALID] = w_beat;
        w_tag_in[TAG_SOF]   = w_beat & w_sof;
        w_tag_in[TAG_EOL]   = w_beat & w_eol;
        w_tag_in[TAG_EOF]   = w_beat & w_eof;
        w_tag_in[TAG_ABORT] = reset_i & w_abort;
    end

    marker_delay_line #(
        .WIDTH (TAG_W),
        .DEPTH (CONV_LATENCY)
    ) u_marker_delay_line (
        .i_clk   (clk_i),
        .i_rst_n (reset_i),
        .i_din   (w_tag_in),
        .o_dout  (w_tag_dly)
    );

    // Stale converter output right after reset must not raise an alignment error
    assign w_chk_en    = (r_sup == '0);
    assign w_align_err = w_chk_en & (w_tag_dly[TAG_VALID] != yuv_valid_i);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_line     <= '0;
            r_first    <= 1'b0;
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
            r_sup      <= SUP_W'(CONV_LATENCY);
        end else begin
            r_state <= w_next_state;
            if (r_sup != '0) begin
                r_sup <= r_sup - 1'b1;
            end
            if (w_beat) begin
                r_first <= 1'b0;
                if (w_eol) begin
                    r_word <= '0;
                    r_line <= w_eof ? '0 : (w_line_cur + 1'b1);
                end else begin
                    r_word <= w_word_cur + 1'b1;
                    r_line <= w_line_cur;
                end
            end else if (w_restart) begin
                r_word  <= '0;
                r_line  <= '0;
                r_first <= 1'b1;
            end
            if (w_drop_inc && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_align_err || (w_chk_en && w_short)) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign w_out_valid  = reset_i & w_tag_dly[TAG_VALID] & yuv_valid_i;
    assign conv_valid_o = w_beat;
    assign out_valid_o  = w_out_valid;
    assign sof_o        = w_out_valid & w_tag_dly[TAG_SOF];
    assign eol_o        = w_out_valid & w_tag_dly[TAG_EOL];
    assign eof_o        = w_out_valid & w_tag_dly[TAG_EOF];
    assign abort_o      = reset_i & w_tag_dly[TAG_ABORT];
    assign err_o        = r_err;
    assign drop_cnt_o   = r_drop_cnt;
    assign busy_o       = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_yuv_frame_ctrl.sv
// Self-checking bench for yuv_frame_ctrl with a 4x2 geometry and a latency-5
// converter model; output tags are checked against a scoreboard queue.
module tb_yuv_frame_ctrl;

    localparam int WPL = 4;
    localparam int LPF = 2;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset_i, enable_i, frame_start_i, rgb_valid_i, fifo_afull_i;
    logic        yuv_valid_i, err_clr_i;
    logic        conv_valid_o, out_valid_o, sof_o, eol_o, eof_o, abort_o, err_o, busy_o;
    logic [15:0] drop_cnt_o;
    logic [LAT-1:0] conv_pipe = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic sof;
        logic eol;
        logic eof;
        int   due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    always #5 clk = ~clk;

    yuv_frame_ctrl #(
        .WORDS_PER_LINE  (WPL),
        .LINES_PER_FRAME (LPF),
        .CONV_LATENCY    (LAT),
        .CNT_W           (12)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .frame_start_i (frame_start_i),
        .rgb_valid_i   (rgb_valid_i),
        .fifo_afull_i  (fifo_afull_i),
        .conv_valid_o  (conv_valid_o),
        .yuv_valid_i   (yuv_valid_i),
        .out_valid_o   (out_valid_o),
        .sof_o         (sof_o),
        .eol_o         (eol_o),
        .eof_o         (eof_o),
        .abort_o       (abort_o),
        .err_clr_i     (err_clr_i),
        .err_o         (err_o),
        .drop_cnt_o    (drop_cnt_o),
        .busy_o        (busy_o)
    );

    // Converter model: fixed latency, not reset, so it keeps emitting in-flight beats
    always @(posedge clk) begin
        conv_pipe <= {conv_pipe[LAT-2:0], conv_valid_o};
        cyc       <= cyc + 1;
    end
    assign yuv_valid_i = conv_pipe[LAT-1];

    always @(negedge clk) begin
        if (out_valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected cyc=%0d out_valid=1 required 0", cyc);
            end else begin
                m_e = sb.pop_front();
                if ({sof_o, eol_o, eof_o} !== {m_e.sof, m_e.eol, m_e.eof}) begin
                    failures++;
                    $display("FAIL sb_tags cyc=%0d sof/eol/eof=%b%b%b required %b%b%b",
                             cyc, sof_o, eol_o, eof_o, m_e.sof, m_e.eol, m_e.eof);
                end
                checks++;
                if (cyc != m_e.due) begin
                    failures++;
                    $display("FAIL sb_latency out at cyc=%0d required cyc=%0d", cyc, m_e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic fs, input logic rv, input logic af);
        frame_start_i = fs;
        rgb_valid_i   = rv;
        fifo_afull_i  = af;
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.sof = (k == 0);
        e.eol = ((k % WPL) == WPL - 1);
        e.eof = (k == WPL * LPF - 1);
        e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic play(input int first, input int last, input bit fs);
        for (int k = first; k <= last; k++) begin
            set_in(fs && (k == first), 1'b1, 1'b0);
            push_exp(k);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * LAT && sb.size() != 0; i++) begin
            tick();
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset_i   = 1'b0;
        enable_i  = 1'b0;
        err_clr_i = 1'b0;
        set_in(1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        checks++; if (conv_valid_o !== 1'b0) begin failures++; $display("FAIL reset_conv got %b required 0", conv_valid_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out got %b required 0", out_valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got %b required 0", err_o); end
        checks++; if (abort_o !== 1'b0) begin failures++; $display("FAIL reset_abort got %b required 0", abort_o); end
        checks++; if (drop_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_drop got %h required 0000", drop_cnt_o); end
        tick();
        reset_i  = 1'b1;
        enable_i = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (conv_valid_o !== 1'b0) begin failures++; $display("FAIL idle_rgb_ignored got %b required 0", conv_valid_o); end
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (LAT + 4) tick();
    endtask

    task automatic test_frame();
        set_in(1'b1, 1'b1, 1'b0);
        push_exp(0);
        @(negedge clk);
        checks++; if (conv_valid_o !== 1'b1) begin failures++; $display("FAIL frame_conv_first got %b required 1", conv_valid_o); end
        tick();
        set_in(1'b0, 1'b1, 1'b0);
        push_exp(1);
        @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL frame_busy got %b required 1", busy_o); end
        tick();
        play(2, 7, 1'b0);
        drain();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL frame_drain pending=%0d required 0", sb.size()); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL frame_err got %b required 0", err_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL frame_busy_end got %b required 0", busy_o); end
    endtask

    task automatic test_overflow();
        play(0, 1, 1'b1);
        set_in(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (conv_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_conv_afull got %b required 0", conv_valid_o); end
        tick();
        for (int i = 1; i <= 6; i++) begin
            set_in(1'b0, logic'(i <= 5), 1'b0);
            @(negedge clk);
            checks++; if (conv_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_conv_after i=%0d got %b required 0", i, conv_valid_o); end
            checks++; if (abort_o !== logic'(i == 5)) begin failures++; $display("FAIL ovf_abort i=%0d got %b required %b", i, abort_o, logic'(i == 5)); end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0);
        checks++; if (drop_cnt_o !== 16'd1) begin failures++; $display("FAIL ovf_drop got %0d required 1", drop_cnt_o); end
        play(0, 7, 1'b1);
        drain();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL ovf_drain pending=%0d required 0", sb.size()); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL ovf_err got %b required 0", err_o); end
        checks++; if (drop_cnt_o !== 16'd1) begin failures++; $display("FAIL ovf_drop_after got %0d required 1", drop_cnt_o); end
    endtask

    task automatic test_short_frame();
        play(0, 4, 1'b1);
        set_in(1'b1, 1'b1, 1'b0);
        push_exp(0);
        tick();
        set_in(1'b0, 1'b1, 1'b0);
        push_exp(1);
        @(negedge clk);
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL short_err_set got %b required 1", err_o); end
        tick();
        play(2, 7, 1'b0);
        drain();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL short_drain pending=%0d required 0", sb.size()); end
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL short_err_sticky got %b required 1", err_o); end
        checks++; if (drop_cnt_o !== 16'd1) begin failures++; $display("FAIL short_drop got %0d required 1", drop_cnt_o); end
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        @(negedge clk);
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL short_err_clr got %b required 0", err_o); end
        tick();
        // clear request colliding with a new short-frame error
        play(0, 2, 1'b1);
        set_in(1'b1, 1'b1, 1'b0);
        err_clr_i = 1'b1;
        push_exp(0);
        tick();
        err_clr_i = 1'b0;
        set_in(1'b0, 1'b1, 1'b0);
        push_exp(1);
        @(negedge clk);
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL short_clr_collide got %b required 1", err_o); end
        tick();
        play(2, 7, 1'b0);
        drain();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL collide_drain pending=%0d required 0", sb.size()); end
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    task automatic test_enable_off();
        play(0, 3, 1'b1);
        enable_i = 1'b0;
        play(4, 7, 1'b0);
        tick();
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL en_off_busy got %b required 0", busy_o); end
        tick();
        for (int k = 0; k < WPL * LPF; k++) begin
            set_in(logic'(k == 0), 1'b1, 1'b0);
            @(negedge clk);
            checks++; if (conv_valid_o !== 1'b0) begin failures++; $display("FAIL en_off_conv k=%0d got %b required 0", k, conv_valid_o); end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0);
        drain();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL en_off_drain pending=%0d required 0", sb.size()); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL en_off_idle got %b required 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL en_off_err got %b required 0", err_o); end
        enable_i = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 5; k++) begin
            set_in(logic'(k == 0), 1'b1, 1'b0);
            @(negedge clk);
            checks++; if (conv_valid_o !== 1'b1) begin failures++; $display("FAIL rst_conv_pre k=%0d got %b required 1", k, conv_valid_o); end
            tick();
        end
        reset_i = 1'b0;
        set_in(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (conv_valid_o !== 1'b0) begin failures++; $display("FAIL rst_conv_in_reset got %b required 0", conv_valid_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_out_in_reset got %b required 0", out_valid_o); end
        tick();
        reset_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            set_in(1'b0, logic'(i <= 2), 1'b0);
            @(negedge clk);
            checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_stale_out i=%0d got %b required 0", i, out_valid_o); end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0);
        repeat (LAT + 3) tick();
        @(negedge clk);
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got %b required 0", err_o); end
        checks++; if (drop_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_drop got %0d required 0", drop_cnt_o); end
        tick();
        play(0, 7, 1'b1);
        drain();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rst_drain pending=%0d required 0", sb.size()); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err_after got %b required 0", err_o); end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 32'hFFFE; n++) begin
            set_in(1'b1, 1'b1, 1'b1);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (drop_cnt_o !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got %h required fffe", drop_cnt_o); end
        tick();
        set_in(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (conv_valid_o !== 1'b0) begin failures++; $display("FAIL sat_conv got %b required 0", conv_valid_o); end
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (drop_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_hit got %h required ffff", drop_cnt_o); end
        tick();
        repeat (2) begin
            set_in(1'b1, 1'b0, 1'b1);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (drop_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got %h required ffff", drop_cnt_o); end
        tick();
    endtask

    initial begin
        reset_i       = 1'b0;
        enable_i      = 1'b0;
        frame_start_i = 1'b0;
        rgb_valid_i   = 1'b0;
        fifo_afull_i  = 1'b0;
        err_clr_i     = 1'b0;
        test_reset();
        test_frame();
        test_overflow();
        test_short_frame();
        test_enable_off();
        test_reset_midframe();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/yuv_frame_ctrl.md
Name: yuv_frame_ctrl

Overview:
Sequences the 4-pixel/clk RGB-to-YUV422 converter between the debayer output and the USB packet FIFO. Arms capture per frame and gates beats into the converter. Counts words and lines against the configured geometry. Delays frame/line markers by the converter's fixed latency so SOF/EOL/EOF align with the YUV words, and drops whole frames when the downstream FIFO cannot absorb them. The converter has no backpressure, so this block is the only flow-control point.

Parameters:
WORDS_PER_LINE, 480, converter beats per line (1920 px / 4).
LINES_PER_FRAME, 1080, lines per frame.
CONV_LATENCY, 5, converter latency in clk_i cycles from rgb valid to yuv valid; must be >= 1.
CNT_W, 12, width of the word and line counters.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
reset_i  in  1  reset; synchronous, active-low.
enable_i  in  1  capture enable; sampled only at frame_start_i.
frame_start_i  in  1  one-cycle pulse marking the first beat of a frame.
rgb_valid_i  in  1  RGB beat valid from the debayer.
fifo_afull_i  in  1  downstream FIFO almost full.
conv_valid_o  out  1  gated valid to the converter's rgb valid input.
yuv_valid_i  in  1  YUV valid returned by the converter.
out_valid_o  out  1  YUV word accepted for the FIFO.
sof_o  out  1  first word of frame, qualified by out_valid_o.
eol_o  out  1  last word of line, qualified by out_valid_o.
eof_o  out  1  last word of frame, qualified by out_valid_o.
abort_o  out  1  one-cycle pulse: current frame truncated.
err_clr_i  in  1  clears err_o.
err_o  out  1  sticky geometry/alignment error.
drop_cnt_o  out  16  count of dropped or aborted frames; saturates at 0xFFFF.
busy_o  out  1  high in ACTIVE.

Behaviour:
- Reset (reset_i=0 at a rising edge):
  - State = IDLE; counters = 0; marker delay line cleared.
  - All outputs 0; drop_cnt_o = 0.
  - err_o and alignment checks are suppressed for CONV_LATENCY cycles after reset release.
- States:
  - IDLE: -> WAIT_SOF when enable_i=1.
  - WAIT_SOF: on frame_start_i with enable_i=1 and fifo_afull_i=0 -> ACTIVE.
    - If fifo_afull_i=1 at that point -> DROP, drop_cnt++.
    - If enable_i=0 -> IDLE.
  - ACTIVE: conv_valid_o = rgb_valid_i (combinational, same cycle).
    - Each valid beat increments the word counter.
    - At word WORDS_PER_LINE-1 the word counter wraps to 0 and the line counter increments.
    - Beat at (WORDS_PER_LINE-1, LINES_PER_FRAME-1): tagged EOF; next state WAIT_SOF, or IDLE if enable_i=0.
  - DROP: conv_valid_o=0. Returns to WAIT_SOF-equivalent handling on the next frame_start_i; that pulse is evaluated exactly as in WAIT_SOF.
- Beat tags (computed when the beat enters the converter):
  - sof = first beat after entering ACTIVE.
  - eol = word counter at WORDS_PER_LINE-1.
  - eof = last beat of the frame.
- Marker delay line:
  - Tags {valid, sof, eol, eof, abort} go into a CONV_LATENCY-deep shift register.
  - out_valid_o = delayed valid AND yuv_valid_i; sof_o/eol_o/eof_o are the delayed tags ANDed with out_valid_o.
  - A mismatch between delayed valid and yuv_valid_i sets err_o.
- FIFO overflow:
  - fifo_afull_i=1 in ACTIVE: that cycle's beat is not forwarded; state -> DROP; drop_cnt++.
  - An abort tag is pushed and emerges CONV_LATENCY cycles later as abort_o.
- Boundary cases:
  - frame_start_i while ACTIVE (short frame): err_o set; counters reset; that beat starts a new frame as SOF. drop_cnt is unchanged.
  - frame_start_i and rgb_valid_i in the same cycle: that beat is word 0 of the new frame.
  - rgb_valid_i outside ACTIVE: ignored, conv_valid_o=0.
  - enable_i deasserted mid-frame: the current frame completes normally.
  - err_clr_i and an error event in the same cycle: the error wins, err_o=1.
  - drop_cnt_o saturates at 0xFFFF.
  - Counters never exceed their parameter limits.

Decomposition:
- Shared package yuv_ctrl_pkg holds:
  - state encoding (IDLE=0, WAIT_SOF=1, ACTIVE=2, DROP=3);
  - the tag bit-index constants;
  - default geometry constants.
- One sub-module: marker_delay_line (parameterised width/depth shift register, synchronous active-low clear).

Test Plan:
1. WORDS_PER_LINE=4, LINES_PER_FRAME=2, enable=1, one frame of 8 contiguous beats, converter model with latency 5 -> 8 out_valid_o:
   - sof_o on word 1, eol_o on words 4 and 8, eof_o on word 8;
   - first out_valid_o 5 cycles after the first conv_valid_o; err_o=0.
2. fifo_afull_i=1 on beat 3 -> conv_valid_o=0 from beat 3 on; abort_o pulses 5 cycles later; drop_cnt_o=1; next frame_start_i (afull=0) captures a full frame.
3. frame_start_i after 5 of 8 beats -> err_o=1; new SOF tagged on that beat; err_clr_i clears err_o to 0.
4. enable_i=0 in the middle of frame 1 -> frame 1 completes with eof_o; frame 2 gets conv_valid_o=0 throughout; state IDLE.
5. reset_i=0 for one cycle mid-frame, with the converter model still emitting 5 stale yuv_valid_i -> out_valid_o=0 for those cycles; err_o stays 0; drop_cnt_o=0.
6. frame_start_i with fifo_afull_i=1 for 0x10001 frames -> drop_cnt_o saturates at 0xFFFF.
